// File: rtl/tdc_line_sampler.sv
// tdc_line_sampler: tapped delay line, 2-flop tap sampling, capture FSM and thermometer encoder
module tdc_line_sampler #(
  parameter int    N        = 64,
  parameter string DL_TYPE  = "DMUX",
  parameter string ENC_MODE = "EDGE",
  parameter int    TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pulse_i,
  input  logic                   arm_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [$clog2(N+1)-1:0] result_o,
  output logic [N-1:0]           raw_o,
  output logic                   ovf_o,
  output logic                   tmo_o,
  output logic                   busy_o
);
  localparam int RW = $clog2(N+1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_ENC   = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  if (N < 8 || N > 256) begin : g_bad_n
    $error("tdc_line_sampler: N must be in 8..256");
  end
  if (DL_TYPE != "DMUX" && DL_TYPE != "DBUF") begin : g_bad_dl
    $error("tdc_line_sampler: DL_TYPE must be DMUX or DBUF");
  end
  if (ENC_MODE != "EDGE" && ENC_MODE != "COUNT") begin : g_bad_enc
    $error("tdc_line_sampler: ENC_MODE must be EDGE or COUNT");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_to
    $error("tdc_line_sampler: TIMEOUT must be in 1..65535");
  end

  logic [1:0]    state;
  logic [N-1:0]  tap, s1, s2, cap;
  logic [15:0]   tcnt;
  logic [N+1:0]  ext;
  logic [RW-1:0] enc, pop, code;

  // Each cell owns its output net so the chain is a plain DAG of separate signals
  for (genvar k = 0; k < N; k++) begin : g_cell
    logic d, t;
    if (k == 0) begin : g_head
      assign d = pulse_i;
    end else begin : g_link
      assign d = g_cell[k-1].t;
    end
    if (DL_TYPE == "DMUX") begin : g_mux
      assign t = d ? 1'b1 : 1'b0;
    end else begin : g_buf
      assign t = d;
    end
    assign tap[k] = t;
  end

  assign busy_o  = state != S_IDLE;
  assign valid_o = state == S_VALID;
  assign code    = (ENC_MODE == "COUNT") ? pop : enc;

  // Encoder: majority-filtered first-zero search and raw popcount over the capture
  always_comb begin
    ext = {1'b0, cap, 1'b1};
    enc = RW'(N);
    pop = '0;
    for (int i = N - 1; i >= 0; i--)
      if (!((ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]))) enc = RW'(i);
    for (int i = 0; i < N; i++)
      pop = pop + RW'(cap[i]);
  end

  // Two-flop synchroniser on every tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= tap;
      s2 <= s1;
    end
  end

  // Measurement FSM: arm, wait for hit or timeout, encode, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cap      <= '0;
      tcnt     <= '0;
      result_o <= '0;
      raw_o    <= '0;
      ovf_o    <= 1'b0;
      tmo_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (arm_i) begin
          state <= S_ARMED;
          tcnt  <= '0;
          tmo_o <= 1'b0;
        end
        S_ARMED: if (s2[0]) begin
          cap   <= s2;
          state <= S_ENC;
        end else if (tcnt == 16'(TIMEOUT - 1)) begin
          cap      <= '0;
          result_o <= '0;
          raw_o    <= '0;
          ovf_o    <= 1'b0;
          tmo_o    <= 1'b1;
          state    <= S_VALID;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
        S_ENC: begin
          result_o <= code;
          raw_o    <= cap;
          ovf_o    <= &cap;
          state    <= S_VALID;
        end
        default: if (ready_i) begin
          state <= arm_i ? S_ARMED : S_IDLE;
          tcnt  <= '0;
          if (arm_i) tmo_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tdc_line_sampler.sv
// tb_tdc_line_sampler: directed and random captures on EDGE/DMUX and COUNT/DBUF instances against a spec-level model
module tb_tdc_line_sampler;
  localparam int N  = 64;
  localparam int RW = $clog2(N + 1);
  localparam int TO = 10;

  logic clk = 1'b0, rst_n = 1'b1, pulse = 1'b0, arm = 1'b0, ready = 1'b0;
  logic ve, vc, oe, oc, te, tc, be, bc;
  logic [RW-1:0] re, rc;
  logic [N-1:0] we, wc, pat;
  int ncomp = 0, nfail = 0;
  int x_re, x_rc, x_lat;
  logic [N-1:0] x_raw;
  logic x_ovf, x_tmo;

  always #5 clk = ~clk;

  tdc_line_sampler #(.N(N), .DL_TYPE("DMUX"), .ENC_MODE("EDGE"), .TIMEOUT(TO)) dut_e (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse), .arm_i(arm), .ready_i(ready),
    .valid_o(ve), .result_o(re), .raw_o(we), .ovf_o(oe), .tmo_o(te), .busy_o(be));

  tdc_line_sampler #(.N(N), .DL_TYPE("DBUF"), .ENC_MODE("COUNT"), .TIMEOUT(TO)) dut_c (
    .clk(clk), .rst_n(rst_n), .pulse_i(pulse), .arm_i(arm), .ready_i(ready),
    .valid_o(vc), .result_o(rc), .raw_o(wc), .ovf_o(oc), .tmo_o(tc), .busy_o(bc));

  task automatic chk(input string t, input logic [N-1:0] o, input logic [N-1:0] e);
    ncomp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  function automatic logic [N-1:0] ones(input int k);
    logic [N-1:0] v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  // First position where at least two of (left, self, right) are zero, with a 1 before tap 0 and a 0 after tap N-1
  function automatic int edge_ref(input logic [N-1:0] q);
    int v [N+2];
    v[0] = 1;
    v[N+1] = 0;
    for (int i = 0; i < N; i++) v[i+1] = int'(q[i]);
    for (int i = 0; i < N; i++) if (v[i] + v[i+1] + v[i+2] < 2) return i;
    return N;
  endfunction

  function automatic void set_exp(input logic [N-1:0] q);
    x_re  = q[0] ? edge_ref(q) : 0;
    x_rc  = q[0] ? $countones(q) : 0;
    x_raw = q[0] ? q : '0;
    x_ovf = q[0] && (q == '1);
    x_tmo = !q[0];
    x_lat = q[0] ? 3 : TO;
  endfunction

  task automatic check_out(input string t);
    chk({t, ".valid_e"}, ve, 1);
    chk({t, ".valid_c"}, vc, 1);
    chk({t, ".busy_e"}, be, 1);
    chk({t, ".busy_c"}, bc, 1);
    chk({t, ".result_e"}, re, x_re);
    chk({t, ".result_c"}, rc, x_rc);
    chk({t, ".raw_e"}, we, x_raw);
    chk({t, ".raw_c"}, wc, x_raw);
    chk({t, ".ovf_e"}, oe, x_ovf);
    chk({t, ".ovf_c"}, oc, x_ovf);
    chk({t, ".tmo_e"}, te, x_tmo);
    chk({t, ".tmo_c"}, tc, x_tmo);
  endtask

  task automatic check_zero(input string t);
    chk({t, ".valid"}, {ve, vc}, 0);
    chk({t, ".busy"}, {be, bc}, 0);
    chk({t, ".result"}, {re, rc}, 0);
    chk({t, ".raw_e"}, we, 0);
    chk({t, ".raw_c"}, wc, 0);
    chk({t, ".flags"}, {oe, oc, te, tc}, 0);
  endtask

  task automatic run(input string t, input logic [N-1:0] p, input bit use_pulse, input int hold);
    int lat;
    set_exp(use_pulse ? '1 : p);
    @(negedge clk);
    pat = p;
    if (use_pulse) pulse = 1'b1;
    else begin
      force dut_e.tap = pat;
      force dut_c.tap = pat;
    end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    lat = 0;
    while (!ve && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({t, ".latency"}, lat, x_lat);
    check_out(t);
    pulse = 1'b0;
    release dut_e.tap;
    release dut_c.tap;
    for (int h = 0; h < hold; h++) begin
      arm = (h == 0);
      @(negedge clk);
      check_out({t, ".hold"});
    end
    arm = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk({t, ".ack_valid"}, {ve, vc}, 0);
    chk({t, ".ack_busy"}, {be, bc}, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat, k;
    logic [N-1:0] p;
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready.busy", {be, bc}, 0);
    chk("idle_ready.valid", {ve, vc}, 0);
    ready = 1'b0;

    run("edge23", ones(23), 1'b0, 0);
    run("bubble12", ones(30) & ~(ones(13) ^ ones(12)), 1'b0, 1);
    run("overflow", '0, 1'b1, 0);
    run("timeout", '0, 1'b0, 5);

    for (int r = 0; r < 16; r++) begin
      k = $urandom_range(1, N);
      p = ones(k);
      if ($urandom_range(0, 2) == 0) p[$urandom_range(0, N - 1)] = ~p[$urandom_range(0, N - 1)];
      if ($urandom_range(0, 2) == 0) p[$urandom_range(0, N - 1)] = 1'b0;
      if ($urandom_range(0, 5) == 0) p[0] = 1'b0;
      run("random", p, 1'b0, $urandom_range(0, 2));
    end

    p = ones(41) & ~(ones(6) ^ ones(5));
    set_exp(p);
    @(negedge clk);
    pat = p;
    force dut_e.tap = pat;
    force dut_c.tap = pat;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    lat = 0;
    while (!ve && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first.latency", lat, 3);
    check_out("b2b_first");
    ready = 1'b1;
    arm = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    arm = 1'b0;
    chk("b2b.gap_valid", {ve, vc}, 0);
    chk("b2b.gap_busy", {be, bc}, 2'b11);
    lat = 0;
    while (!ve && lat < 40) begin
      @(negedge clk);
      lat++;
      chk("b2b.busy", {be, bc}, 2'b11);
    end
    chk("b2b_second.latency", lat, 2);
    check_out("b2b_second");
    release dut_e.tap;
    release dut_c.tap;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (2) @(negedge clk);

    pat = ones(17);
    force dut_e.tap = pat;
    force dut_c.tap = pat;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    chk("enc_reset.pre_busy", {be, bc}, 2'b11);
    chk("enc_reset.pre_valid", {ve, vc}, 0);
    rst_n = 1'b0;
    #1 check_zero("enc_reset");
    release dut_e.tap;
    release dut_c.tap;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("enc_reset.post_valid", {ve, vc}, 0);
      chk("enc_reset.post_busy", {be, bc}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
